// File: rtl/mem_arb_pkg.sv
// Shared types and geometry for the I/D-cache memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned WORDS_PER_BLK = 8;
  localparam int unsigned MEM_LAT       = 4;
  localparam int unsigned BLK_OFF_LSB   = 1;
  localparam int unsigned BLK_OFF_MSB   = 3;

  // Derived: first block-tag bit, word-select width, issue counter width (needs the saturate value 8).
  localparam int unsigned BLK_LSB = BLK_OFF_MSB + 1;
  localparam int unsigned WSEL_W  = BLK_OFF_MSB - BLK_OFF_LSB + 1;
  localparam int unsigned ICNT_W  = WSEL_W + 1;
  localparam int unsigned TAG_W   = ADDR_W - BLK_LSB;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} arbState_t;
  typedef enum logic [1:0] {I_FILL, D_FILL, D_WRITE} reqKind_t;

  // Block-aligned base of a byte address.
  function automatic logic [ADDR_W-1:0] blkBase(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:BLK_LSB], {BLK_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_arbiter_fill_seq.sv
// Block-fill sequencer: read-issue counter, return counter, read address and last-word flag.
module fill_seq
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              dataValid,
  input  logic [TAG_W-1:0]  blkTag,
  output logic              issueActive,
  output logic [ADDR_W-1:0] rdAddr,
  output logic [WSEL_W-1:0] wordSel,
  output logic              lastWord
);

  logic [ICNT_W-1:0] issueCnt;
  logic [WSEL_W-1:0] recvCnt;

  assign issueActive = issueCnt < ICNT_W'(WORDS_PER_BLK);
  assign rdAddr      = {blkTag, issueCnt[WSEL_W-1:0], {BLK_OFF_LSB{1'b0}}};
  assign wordSel     = recvCnt;
  assign lastWord    = recvCnt == WSEL_W'(WORDS_PER_BLK - 1);

  // Counters advance only while a fill runs; issue saturates at one block, cleared otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issueCnt <= '0;
      recvCnt  <= '0;
    end else if (!run) begin
      issueCnt <= '0;
      recvCnt  <= '0;
    end else begin
      if (issueActive) issueCnt <= issueCnt + ICNT_W'(1);
      if (dataValid)   recvCnt  <= recvCnt + WSEL_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared pipelined main memory between I-cache fills, D-cache fills and D-cache stores.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  input  logic              dcache_wr_req,
  input  logic [ADDR_W-1:0] dcache_wr_addr,
  input  logic [DATA_W-1:0] dcache_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid,
  output logic              fill_target,
  output logic              fill_data_we,
  output logic [WSEL_W-1:0] fill_word_sel,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_tag_we,
  output logic              icache_fill_done,
  output logic              dcache_fill_done,
  output logic              dcache_wr_done,
  output logic              busy
);

  arbState_t         state;
  reqKind_t          kind;
  logic [ADDR_W-1:0] latchAddr;
  logic [DATA_W-1:0] latchData;
  logic              latchTarget;

  logic              fillActive;
  logic              issueActive;
  logic [ADDR_W-1:0] rdAddr;
  logic [WSEL_W-1:0] wordSel;
  logic              lastWord;
  logic              recvValid;

  assign fillActive = state == FILL;
  assign recvValid  = fillActive && mem_data_valid;

  fill_seq uFillSeq (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (fillActive),
    .dataValid   (recvValid),
    .blkTag      (latchAddr[ADDR_W-1:BLK_LSB]),
    .issueActive (issueActive),
    .rdAddr      (rdAddr),
    .wordSel     (wordSel),
    .lastWord    (lastWord)
  );

  // Arbitration and service FSM; requests are only sampled in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      kind        <= I_FILL;
      latchAddr   <= '0;
      latchData   <= '0;
      latchTarget <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dcache_miss) begin
            kind        <= D_FILL;
            latchAddr   <= blkBase(dcache_miss_addr);
            latchTarget <= 1'b1;
            state       <= FILL;
          end else if (dcache_wr_req) begin
            kind        <= D_WRITE;
            latchAddr   <= dcache_wr_addr;
            latchData   <= dcache_wr_data;
            latchTarget <= 1'b1;
            state       <= WRITE;
          end else if (icache_miss) begin
            kind        <= I_FILL;
            latchAddr   <= blkBase(icache_miss_addr);
            latchTarget <= 1'b0;
            state       <= FILL;
          end
        end
        FILL:    if (mem_data_valid && lastWord) state <= DONE;
        WRITE:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port is decoded from state so reset clears it immediately.
  assign mem_en      = (fillActive && issueActive) || (state == WRITE);
  assign mem_wr      = state == WRITE;
  assign mem_addr    = (state == WRITE) ? latchAddr :
                       (fillActive && issueActive) ? rdAddr : '0;
  assign mem_data_in = (state == WRITE) ? latchData : '0;

  // Fill write port passes returns straight through; stray returns outside FILL are dropped.
  assign fill_target   = latchTarget;
  assign fill_data_we  = recvValid;
  assign fill_word_sel = wordSel;
  assign fill_data     = recvValid ? mem_data_out : '0;
  assign fill_tag_we   = recvValid && lastWord;

  assign icache_fill_done = (state == DONE) && (kind == I_FILL);
  assign dcache_fill_done = (state == DONE) && (kind == D_FILL);
  assign dcache_wr_done   = (state == DONE) && (kind == D_WRITE);
  assign busy             = state != IDLE;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a 4-cycle pipelined memory model.
module tb_mem_arbiter;

  localparam int KI = 0;
  localparam int KD = 1;
  localparam int KW = 2;

  logic        clk;
  logic        rst_n;
  logic        icache_miss;
  logic [15:0] icache_miss_addr;
  logic        dcache_miss;
  logic [15:0] dcache_miss_addr;
  logic        dcache_wr_req;
  logic [15:0] dcache_wr_addr;
  logic [15:0] dcache_wr_data;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic        fill_target;
  logic        fill_data_we;
  logic [2:0]  fill_word_sel;
  logic [15:0] fill_data;
  logic        fill_tag_we;
  logic        icache_fill_done;
  logic        dcache_fill_done;
  logic        dcache_wr_done;
  logic        busy;

  int nRun;
  int nFail;

  logic [15:0] salt;
  logic [15:0] memArr [logic [15:0]];
  logic        pipeVld [4];
  logic [15:0] pipeDat [4];
  logic        spurValid;

  mem_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .icache_miss      (icache_miss),
    .icache_miss_addr (icache_miss_addr),
    .dcache_miss      (dcache_miss),
    .dcache_miss_addr (dcache_miss_addr),
    .dcache_wr_req    (dcache_wr_req),
    .dcache_wr_addr   (dcache_wr_addr),
    .dcache_wr_data   (dcache_wr_data),
    .mem_en           (mem_en),
    .mem_wr           (mem_wr),
    .mem_addr         (mem_addr),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (mem_data_out),
    .mem_data_valid   (mem_data_valid),
    .fill_target      (fill_target),
    .fill_data_we     (fill_data_we),
    .fill_word_sel    (fill_word_sel),
    .fill_data        (fill_data),
    .fill_tag_we      (fill_tag_we),
    .icache_fill_done (icache_fill_done),
    .dcache_fill_done (dcache_fill_done),
    .dcache_wr_done   (dcache_wr_done),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: written words, else a salted hash of the address.
  function automatic logic [15:0] memRead(input logic [15:0] a);
    logic [31:0] p;
    if (memArr.exists(a)) return memArr[a];
    p = {16'h0, a} * 32'h0000_9E37;
    return p[15:0] ^ salt;
  endfunction

  // Pipelined memory: a read issued in cycle t returns in cycle t+4; unaffected by arbiter reset.
  always @(posedge clk) begin
    pipeVld[0] <= mem_en && !mem_wr;
    pipeDat[0] <= memRead(mem_addr);
    for (int i = 1; i < 4; i++) begin
      pipeVld[i] <= pipeVld[i-1];
      pipeDat[i] <= pipeDat[i-1];
    end
    if (mem_en && mem_wr) memArr[mem_addr] = mem_data_in;
  end

  assign mem_data_valid = pipeVld[3] || spurValid;
  assign mem_data_out   = pipeDat[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nRun++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dropReq(input int kind);
    case (kind)
      KI:      icache_miss = 1'b0;
      KD:      dcache_miss = 1'b0;
      default: dcache_wr_req = 1'b0;
    endcase
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, " mem_en"}, 32'(mem_en), 0);
    chk({tag, " mem_wr"}, 32'(mem_wr), 0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 0);
    chk({tag, " mem_data_in"}, 32'(mem_data_in), 0);
    chk({tag, " fill_target"}, 32'(fill_target), 0);
    chk({tag, " fill_data_we"}, 32'(fill_data_we), 0);
    chk({tag, " fill_word_sel"}, 32'(fill_word_sel), 0);
    chk({tag, " fill_data"}, 32'(fill_data), 0);
    chk({tag, " fill_tag_we"}, 32'(fill_tag_we), 0);
    chk({tag, " i_done"}, 32'(icache_fill_done), 0);
    chk({tag, " d_done"}, 32'(dcache_fill_done), 0);
    chk({tag, " wr_done"}, 32'(dcache_wr_done), 0);
    chk({tag, " busy"}, 32'(busy), 0);
  endtask

  // Called at the falling edge of cycle 0 (request visible); checks every cycle of the service
  // against the fixed fill/store timeline, then the following idle cycle.
  task automatic checkService(input int kind, input logic [15:0] addr, input logic [15:0] data,
                              input int dropAt, input int stopAt);
    logic [15:0] base;
    logic [15:0] expAddr;
    int          last;
    string       t;
    base = {addr[15:4], 4'h0};
    last = (kind == KW) ? 2 : 13;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == dropAt) dropReq(kind);
      t = $sformatf("k%0d a%04h c%0d", kind, addr, c);
      chk({t, " busy"}, 32'(busy), 1);
      chk({t, " fill_target"}, 32'(fill_target), (kind != KI) ? 1 : 0);
      if (kind == KW) begin
        chk({t, " mem_en"}, 32'(mem_en), (c == 1) ? 1 : 0);
        if (c == 1) begin
          chk({t, " mem_wr"}, 32'(mem_wr), 1);
          chk({t, " mem_addr"}, 32'(mem_addr), 32'(addr));
          chk({t, " mem_data_in"}, 32'(mem_data_in), 32'(data));
        end
        chk({t, " fill_data_we"}, 32'(fill_data_we), 0);
        chk({t, " wr_done"}, 32'(dcache_wr_done), (c == 2) ? 1 : 0);
        chk({t, " d_done"}, 32'(dcache_fill_done), 0);
        chk({t, " i_done"}, 32'(icache_fill_done), 0);
      end else begin
        chk({t, " mem_en"}, 32'(mem_en), (c <= 8) ? 1 : 0);
        if (c <= 8) begin
          expAddr = base + 16'(2 * (c - 1));
          chk({t, " mem_wr"}, 32'(mem_wr), 0);
          chk({t, " mem_addr"}, 32'(mem_addr), 32'(expAddr));
        end
        chk({t, " fill_data_we"}, 32'(fill_data_we), (c >= 5 && c <= 12) ? 1 : 0);
        if (c >= 5 && c <= 12) begin
          expAddr = base + 16'(2 * (c - 5));
          chk({t, " fill_word_sel"}, 32'(fill_word_sel), 32'(c - 5));
          chk({t, " fill_data"}, 32'(fill_data), 32'(memRead(expAddr)));
        end
        chk({t, " fill_tag_we"}, 32'(fill_tag_we), (c == 12) ? 1 : 0);
        chk({t, " i_done"}, 32'(icache_fill_done), (c == 13 && kind == KI) ? 1 : 0);
        chk({t, " d_done"}, 32'(dcache_fill_done), (c == 13 && kind == KD) ? 1 : 0);
        chk({t, " wr_done"}, 32'(dcache_wr_done), 0);
      end
      if (c == stopAt) return;
    end
    dropReq(kind);
    @(negedge clk);
    chk($sformatf("k%0d a%04h idle_after busy", kind, addr), 32'(busy), 0);
  endtask

  initial begin
    logic [15:0] aI;
    logic [15:0] aD;
    logic [15:0] aW;
    logic [15:0] dW;
    int          mask;
    nRun  = 0;
    nFail = 0;
    salt  = 16'($urandom);
    rst_n = 1'b0;
    spurValid = 1'b0;
    icache_miss = 1'b0; icache_miss_addr = '0;
    dcache_miss = 1'b0; dcache_miss_addr = '0;
    dcache_wr_req = 1'b0; dcache_wr_addr = '0; dcache_wr_data = '0;
    for (int i = 0; i < 4; i++) begin
      pipeVld[i] = 1'b0;
      pipeDat[i] = '0;
    end
    repeat (2) @(negedge clk);
    chkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Lone I-cache miss.
    icache_miss = 1'b1; icache_miss_addr = 16'h1236;
    checkService(KI, 16'h1236, 16'h0, 0, 0);

    // Three simultaneous requests: D fill, then store, then I fill.
    aW = 16'($urandom); dW = 16'($urandom); aI = 16'($urandom);
    dcache_miss = 1'b1; dcache_miss_addr = 16'h4008;
    dcache_wr_req = 1'b1; dcache_wr_addr = aW; dcache_wr_data = dW;
    icache_miss = 1'b1; icache_miss_addr = aI;
    checkService(KD, 16'h4008, 16'h0, 0, 0);
    checkService(KW, aW, dW, 0, 0);
    checkService(KI, aI, 16'h0, 0, 0);

    // Store.
    dcache_wr_req = 1'b1; dcache_wr_addr = 16'h2002; dcache_wr_data = 16'hBEEF;
    checkService(KW, 16'h2002, 16'hBEEF, 0, 0);

    // Spurious return while idle.
    spurValid = 1'b1;
    #1;
    chk("spur fill_data_we", 32'(fill_data_we), 0);
    chk("spur fill_tag_we", 32'(fill_tag_we), 0);
    @(negedge clk);
    spurValid = 1'b0;
    chk("spur busy", 32'(busy), 0);
    @(negedge clk);
    chk("spur busy2", 32'(busy), 0);

    // D miss dropped mid-service still completes.
    aD = 16'($urandom);
    dcache_miss = 1'b1; dcache_miss_addr = aD;
    checkService(KD, aD, 16'h0, 3, 0);

    // Reset in cycle 6 of a D fill, stale returns ignored, then a clean I fill.
    aD = 16'($urandom);
    dcache_miss = 1'b1; dcache_miss_addr = aD;
    checkService(KD, aD, 16'h0, 0, 6);
    rst_n = 1'b0;
    dcache_miss = 1'b0;
    #1;
    chkAllZero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("postreset%0d fill_data_we", k), 32'(fill_data_we), 0);
      chk($sformatf("postreset%0d fill_tag_we", k), 32'(fill_tag_we), 0);
      chk($sformatf("postreset%0d busy", k), 32'(busy), 0);
    end
    aI = 16'($urandom);
    icache_miss = 1'b1; icache_miss_addr = aI;
    checkService(KI, aI, 16'h0, 0, 0);

    // Random request mixes served in fixed priority order, losers held.
    for (int n = 0; n < 20; n++) begin
      mask = int'($urandom_range(1, 7));
      aI = 16'($urandom); aD = 16'($urandom); aW = 16'($urandom); dW = 16'($urandom);
      if (mask[0]) begin icache_miss = 1'b1; icache_miss_addr = aI; end
      if (mask[1]) begin dcache_miss = 1'b1; dcache_miss_addr = aD; end
      if (mask[2]) begin dcache_wr_req = 1'b1; dcache_wr_addr = aW; dcache_wr_data = dW; end
      if (mask[1]) checkService(KD, aD, 16'h0, 0, 0);
      if (mask[2]) checkService(KW, aW, dW, 0, 0);
      if (mask[0]) checkService(KI, aI, 16'h0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single 4-cycle-latency, pipelined main memory between the instruction-cache and data-cache controllers. Serves one requester at a time:
- I-cache miss: 8-word block fill.
- D-cache miss: 8-word block fill.
- D-cache store: single-word write-through.

Sits between the two caches and the memory model. The cache controller's miss stall is released by this block's done pulses.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- WORDS_PER_BLK, 8, words per cache block (16-byte block)
- MEM_LAT, 4, cycles from read issue to mem_data_valid
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- icache_miss  in  1  I-cache requests block fill (held until icache_fill_done)
- icache_miss_addr  in  ADDR_W  missing instruction address
- dcache_miss  in  1  D-cache requests block fill (held until dcache_fill_done)
- dcache_miss_addr  in  ADDR_W  missing data address
- dcache_wr_req  in  1  D-cache store to memory (held until dcache_wr_done)
- dcache_wr_addr  in  ADDR_W  store address
- dcache_wr_data  in  DATA_W  store data
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  1 = write, 0 = read (valid when mem_en)
- mem_addr  out  ADDR_W  memory byte address
- mem_data_in  out  DATA_W  write data to memory
- mem_data_out  in  DATA_W  read data from memory
- mem_data_valid  in  1  mem_data_out valid
- fill_target  out  1  0 = I-cache, 1 = D-cache (valid while busy)
- fill_data_we  out  1  write fill_data into target data array
- fill_word_sel  out  3  word offset within block for fill_data
- fill_data  out  DATA_W  fill word (= mem_data_out)
- fill_tag_we  out  1  write tag/valid of target for latched block
- icache_fill_done  out  1  one-cycle pulse, I fill complete
- dcache_fill_done  out  1  one-cycle pulse, D fill complete
- dcache_wr_done  out  1  one-cycle pulse, store complete
- busy  out  1  state != IDLE

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - Priority is dcache_miss > dcache_wr_req > icache_miss.
  - On a sampled request, latch the block address ({addr[15:4], 4'b0}) or the store addr/data, and the target/kind.
  - Go to FILL or WRITE.
- FILL, issue side:
  - issue_cnt runs 0..7.
  - Each cycle with issue_cnt < 8: mem_en=1, mem_wr=0, mem_addr = {blk[15:4], issue_cnt, 1'b0}; then issue_cnt++.
  - issue_cnt saturates at 8; it never wraps.
- FILL, receive side:
  - recv_cnt runs 0..7.
  - On mem_data_valid: fill_data_we=1, fill_word_sel=recv_cnt, fill_data=mem_data_out; then recv_cnt++.
  - On the valid with recv_cnt==7: fill_tag_we=1 in the same cycle, then go to DONE.
- WRITE: one cycle with mem_en=1, mem_wr=1, mem_addr=latched addr, mem_data_in=latched data; then go to DONE.
- DONE:
  - Pulse the done output matching the latched kind.
  - Return to IDLE.
  - No new request is accepted in DONE.
- mem_data_valid outside FILL is ignored; no data-array or tag write results.
- A requester dropping its request mid-service does not abort; the service completes and done still pulses.
- A losing requester is not queued. It must hold its request; it is served on a later IDLE cycle.
- Back-to-back requests of the same kind are allowed after DONE.

## Timing
- Reset (async assert, sync deassert by clk):
  - state=IDLE, counters=0.
  - All outputs 0: mem_en, mem_wr, mem_addr, mem_data_in, fill_*, done pulses, busy.
- Reset mid-FILL: in-flight returns arrive in IDLE and are ignored.
- Cycle numbering: cycle 0 is the IDLE cycle in which the request is sampled.
- Fill sequence:
  - Reads issue in cycles 1–8.
  - Data is valid in cycles 5–12.
  - fill_tag_we is asserted in cycle 12.
  - The done pulse is in cycle 13.
  - The earliest next acceptance is cycle 14.
- Store sequence: write in cycle 1, dcache_wr_done in cycle 2, next acceptance in cycle 3.
- busy is high in cycles 1 through done inclusive.
- All outputs are registered or state-decoded. fill_data and fill_data_we are combinational from mem_data_out/mem_data_valid.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, FILL, WRITE, DONE);
  - the kind enum (I_FILL, D_FILL, D_WRITE);
  - BLK_OFF_LSB=1, BLK_OFF_MSB=3, WORDS_PER_BLK.
- Sub-module fill_seq holds issue_cnt/recv_cnt and generates the read addresses, fill_word_sel and the last-word flag.
- The top level holds the FSM, arbitration and latches.

## Test plan
- I-cache miss at 0x1236 alone -> reads 0x1230..0x123E in cycles 1–8; fill_word_sel 0..7 in cycles 5–12; fill_target=0; fill_tag_we in cycle 12; icache_fill_done in cycle 13.
- dcache_miss 0x4008, dcache_wr_req, icache_miss asserted together -> D fill served first (addresses 0x4000..0x400E); store next; I fill last. Each starts one cycle after the previous done.
- Store 0x2002 <= 0xBEEF -> cycle 1 mem_en=1, mem_wr=1, addr 0x2002, data 0xBEEF; dcache_wr_done in cycle 2; busy low in cycle 3.
- Spurious mem_data_valid while IDLE -> no fill_data_we, no fill_tag_we, state stays IDLE.
- rst_n low in cycle 6 of a D fill -> all outputs 0 immediately. Post-reset valid pulses are ignored. A new I miss then completes normally with 8 fresh reads.
- dcache_miss dropped in cycle 3 -> fill still completes with all 8 words and dcache_fill_done pulses in cycle 13.
